// File: rtl/conv_seq_ctrl.sv
// Sequences a 1-D convolution of two word memories into a third, one output per pass over its valid terms.
// Per output: SETUP, L_k FETCH cycles, DRAIN, WRITE; en_s=0 freezes everything and masks z_we/done.
module conv_seq_ctrl #(
  parameter int DATAWIDTH = 32,
  parameter int AW        = 5,
  parameter int ZAW       = 6
) (
  input  logic                 clk,
  input  logic                 rst_a,
  input  logic                 en_s,
  input  logic                 start,
  input  logic [10:0]          conf,
  output logic [AW-1:0]        x_addr,
  output logic [AW-1:0]        y_addr,
  input  logic [DATAWIDTH-1:0] x_data,
  input  logic [DATAWIDTH-1:0] y_data,
  output logic [ZAW-1:0]       z_addr,
  output logic [DATAWIDTH-1:0] z_data,
  output logic                 z_we,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int IW = ((ZAW > AW) ? ZAW : AW) + 1;
  localparam logic [IW-1:0] ONE = IW'(1);

  typedef enum logic [2:0] {IDLE, SETUP, FETCH, DRAIN, WRITE, FIN} state_t;

  state_t               state;
  logic [4:0]           nx;
  logic [4:0]           ny;
  logic [ZAW-1:0]       k;
  logic [ZAW-1:0]       kmax;
  logic [IW-1:0]        off;
  logic [IW-1:0]        j;
  logic [IW-1:0]        jend;
  logic [IW-1:0]        yj;
  logic [DATAWIDTH-1:0] acc;
  logic                 fetch_vld;
  logic                 z_we_q;
  logic                 done_q;

  logic [IW-1:0]        nx_w, ny_w, kf, jmin, jmax, cnx, cny;
  logic [DATAWIDTH-1:0] prod;

  assign prod = x_data * y_data;
  assign z_we = z_we_q & en_s;
  assign done = done_q & en_s;

  // Term bounds for the current output, in the full-convolution index domain.
  always_comb begin
    nx_w = IW'(nx);
    ny_w = IW'(ny);
    cnx  = IW'(conf[4:0]);
    cny  = IW'(conf[9:5]);
    kf   = IW'(k) + off;
    jmin = ((kf + ONE) > ny_w) ? (kf + ONE - ny_w) : '0;
    jmax = (kf < nx_w) ? kf : (nx_w - ONE);
  end

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      state     <= IDLE;
      nx        <= '0;
      ny        <= '0;
      k         <= '0;
      kmax      <= '0;
      off       <= '0;
      j         <= '0;
      jend      <= '0;
      yj        <= '0;
      acc       <= '0;
      fetch_vld <= 1'b0;
      x_addr    <= '0;
      y_addr    <= '0;
      z_addr    <= '0;
      z_data    <= '0;
      z_we_q    <= 1'b0;
      done_q    <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else if (en_s) begin
      // Read data lags the address by one cycle, so accumulation trails FETCH by one.
      fetch_vld <= (state == FETCH);
      if (fetch_vld) acc <= acc + prod;

      case (state)
        IDLE: begin
          if (start) begin
            nx   <= conf[4:0];
            ny   <= conf[9:5];
            k    <= '0;
            busy <= 1'b1;
            kmax <= ZAW'(conf[10] ? (cnx + cny - ONE - ONE) : (cnx - ONE));
            off  <= conf[10] ? '0 : (cny >> 1);
            if (conf[4:0] == 5'd0 || conf[9:5] == 5'd0) begin
              err    <= 1'b1;
              done_q <= 1'b1;
              state  <= FIN;
            end else begin
              err   <= 1'b0;
              state <= SETUP;
            end
          end
        end
        SETUP: begin
          acc    <= '0;
          j      <= jmin;
          jend   <= jmax;
          yj     <= kf - jmin;
          x_addr <= AW'(jmin);
          y_addr <= AW'(kf - jmin);
          state  <= FETCH;
        end
        FETCH: begin
          if (j == jend) begin
            state <= DRAIN;
          end else begin
            j      <= j + ONE;
            yj     <= yj - ONE;
            x_addr <= AW'(j + ONE);
            y_addr <= AW'(yj - ONE);
          end
        end
        DRAIN: begin
          z_data <= acc + prod;
          z_addr <= k;
          z_we_q <= 1'b1;
          state  <= WRITE;
        end
        WRITE: begin
          z_we_q <= 1'b0;
          if (k == kmax) begin
            done_q <= 1'b1;
            state  <= FIN;
          end else begin
            k     <= k + ZAW'(1);
            state <= SETUP;
          end
        end
        FIN: begin
          done_q <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Directed scoreboard bench for conv_seq_ctrl: expected writes queued at stimulus, popped by a write monitor.
module tb_conv_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_a = 1'b0;
  logic        en_s = 1'b1;
  logic        start = 1'b0;
  logic [10:0] conf = '0;
  logic [4:0]  x_addr, y_addr;
  logic [31:0] x_data = '0, y_data = '0;
  logic [5:0]  z_addr;
  logic [31:0] z_data;
  logic        z_we, busy, done, err;

  conv_seq_ctrl #(.DATAWIDTH(32), .AW(5), .ZAW(6)) dut (
    .clk(clk), .rst_a(rst_a), .en_s(en_s), .start(start), .conf(conf),
    .x_addr(x_addr), .y_addr(y_addr), .x_data(x_data), .y_data(y_data),
    .z_addr(z_addr), .z_data(z_data), .z_we(z_we),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  logic [31:0] xmem [32];
  logic [31:0] ymem [32];

  always @(posedge clk) begin
    x_data <= xmem[x_addr];
    y_data <= ymem[y_addr];
  end

  typedef struct {
    logic [5:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t sb[$];
  int  checks = 0;
  int  errors = 0;
  int  done_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_a) begin
      if (z_we) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: z_addr=%0d z_data=0x%0h, expected no write", z_addr, z_data);
        end else begin
          wr_t e;
          e = sb.pop_front();
          chk("z_addr", 64'(z_addr), 64'(e.a));
          chk("z_data", 64'(z_data), 64'(e.d));
        end
      end
      if (done) done_cnt++;
    end
  end

  function automatic logic [10:0] mk(input bit shape, input int ny, input int nx);
    logic [10:0] c;
    c = {shape, 5'(ny), 5'(nx)};
    return c;
  endfunction

  task automatic push(input int a, input logic [31:0] d);
    wr_t e;
    e.a = 6'(a);
    e.d = d;
    sb.push_back(e);
  endtask

  // Cycle 1 is the cycle after the edge that samples start.
  task automatic run(input string name, input logic [10:0] c, input int exp_lat,
                     input int stall_at, input bit restart);
    int cyc;
    int d0;
    d0 = done_cnt;
    @(negedge clk);
    conf  = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    conf  = ~c;
    cyc   = 1;
    chk({name, " busy_after_start"}, 64'(busy), 64'(1));
    while (cyc < 300) begin
      if (done) break;
      if (stall_at > 0 && cyc == stall_at) en_s = 1'b0;
      if (stall_at > 0 && cyc == stall_at + 5) en_s = 1'b1;
      if (restart && cyc == 2) start = 1'b1;
      if (restart && cyc == 3) start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    en_s  = 1'b1;
    start = 1'b0;
    chk({name, " done_latency"}, 64'(cyc), 64'(exp_lat));
    @(negedge clk);
    chk({name, " busy_idle"}, 64'(busy), 64'(0));
    chk({name, " done_count"}, 64'(done_cnt - d0), 64'(1));
    chk({name, " writes_left"}, 64'(sb.size()), 64'(0));
    sb.delete();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      xmem[i] = '0;
      ymem[i] = '0;
    end
    #1;
    chk("rst busy", 64'(busy), 64'(0));
    chk("rst done", 64'(done), 64'(0));
    chk("rst err", 64'(err), 64'(0));
    chk("rst z_we", 64'(z_we), 64'(0));
    chk("rst addrs", {40'(0), x_addr, y_addr, z_addr, 8'(0)}, 64'(0));
    chk("rst z_data", 64'(z_data), 64'(0));
    #24;
    rst_a = 1'b1;

    // 1x1 full: z[0]=3*4
    xmem[0] = 32'd3; ymem[0] = 32'd4;
    push(0, 32'd12);
    run("t1x1", mk(1, 1, 1), 5, 0, 1'b0);

    // 3x2 full: costs 4+5+5+4, done in cycle 19
    xmem[0] = 32'd1; xmem[1] = 32'd2; xmem[2] = 32'd3;
    ymem[0] = 32'd1; ymem[1] = 32'd1;
    push(0, 32'd1); push(1, 32'd3); push(2, 32'd5); push(3, 32'd3);
    run("full3x2", mk(1, 2, 3), 19, 0, 1'b0);

    // same shape keeps full[1..3]
    push(0, 32'd3); push(1, 32'd5); push(2, 32'd3);
    run("same3x2", mk(0, 2, 3), 15, 0, 1'b0);

    // Nx=0: error, immediate FIN, no writes
    run("nx0", mk(1, 2, 0), 1, 0, 1'b0);
    chk("nx0 err", 64'(err), 64'(1));

    // wrap check, start re-asserted while busy
    xmem[0] = 32'hFFFF_FFFF; ymem[0] = 32'd2;
    push(0, 32'hFFFF_FFFE);
    run("wrap", mk(1, 1, 1), 5, 0, 1'b1);
    chk("wrap err_cleared", 64'(err), 64'(0));

    // 5-cycle enable drop during FETCH of output 1
    xmem[0] = 32'd1;
    ymem[0] = 32'd1;
    push(0, 32'd1); push(1, 32'd3); push(2, 32'd5); push(3, 32'd3);
    run("stall", mk(1, 2, 3), 24, 6, 1'b0);

    // reset mid-run after the first write
    push(0, 32'd1); push(1, 32'd3); push(2, 32'd5); push(3, 32'd3);
    begin
      int d0;
      d0 = done_cnt;
      @(negedge clk);
      conf  = mk(1, 2, 3);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      chk("midrst writes_left", 64'(sb.size()), 64'(3));
      rst_a = 1'b0;
      #1;
      chk("midrst busy", 64'(busy), 64'(0));
      chk("midrst z_we", 64'(z_we), 64'(0));
      chk("midrst z_data", 64'(z_data), 64'(0));
      sb.delete();
      repeat (2) @(negedge clk);
      rst_a = 1'b1;
      repeat (30) @(negedge clk);
      chk("midrst no_done", 64'(done_cnt - d0), 64'(0));
      chk("midrst idle", 64'(busy), 64'(0));
    end

    // fresh run after reset
    xmem[0] = 32'd3; ymem[0] = 32'd4;
    push(0, 32'd12);
    run("fresh", mk(1, 1, 1), 5, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_seq_ctrl.md
CONV_SEQ_CTRL -- requirements
Module: conv_seq_ctrl

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 32, the sample, accumulator and output word width.
REQ-002 SHALL have parameter AW, default 5, the X/Y memory address width (32 words each).
REQ-003 SHALL have parameter ZAW, default 6, the Z memory address width (64 words).
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst_a  in  1  reset, asynchronous, active-low.
REQ-006 en_s  in  1  synchronous enable; low freezes all state.
REQ-007 start  in  1  start request, sampled in IDLE only.
REQ-008 conf  in  11  configuration: [4:0]=Nx (X length), [9:5]=Ny (Y length), [10]=shape (1=full, 0=same).
REQ-009 x_addr / y_addr  out  AW  X and Y memory read addresses.
REQ-010 x_data / y_data  in  DATAWIDTH  X and Y read data, valid one cycle after the address.
REQ-011 z_addr  out  ZAW  Z memory write address.
REQ-012 z_data  out  DATAWIDTH  Z memory write data.
REQ-013 z_we  out  1  Z write strobe.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle completion pulse.
REQ-016 err  out  1  latched config error; cleared by the next accepted start.

Function
REQ-017 SHALL implement states IDLE, SETUP, FETCH, DRAIN, WRITE, FIN.
REQ-018 In IDLE with start=1 and en_s=1: SHALL latch conf and go to SETUP.
- Output index k=0, the output count, and the term bounds are computed at this point.
REQ-019 Full shape: SHALL produce K=Nx+Ny-1 outputs z[k]=sum of x[j]*y[k-j], j from max(0,k-Ny+1) to min(k,Nx-1).
REQ-020 Same shape: SHALL produce K=Nx outputs z[i]=full[i+floor(Ny/2)], written to z_addr=i.
REQ-021 SETUP: SHALL clear the accumulator, load j=jmin, and go to FETCH.
REQ-022 FETCH: SHALL issue one address pair per cycle, x_addr=j and y_addr=k'-j (k' = full-domain index).
- Stays in FETCH for L_k = jmax-jmin+1 cycles, then goes to DRAIN.
REQ-023 SHALL update acc = acc + x_data*y_data on the cycle after each address issue.
- Arithmetic is unsigned, product truncated to DATAWIDTH, sum modulo 2^DATAWIDTH.
REQ-024 DRAIN: SHALL accumulate the last product, then go to WRITE.
REQ-025 WRITE: SHALL assert z_we=1 for exactly one cycle with z_addr=k and z_data=acc.
- If k<K-1: increment k and return to SETUP; otherwise go to FIN.
REQ-026 Per-output cost SHALL be L_k+3 cycles.
REQ-027 FIN: SHALL assert done=1 for one cycle, then return to IDLE.
REQ-028 If Nx=0 or Ny=0 at start: SHALL set err=1 and go directly to FIN (no writes); done still pulses.
REQ-029 start while busy SHALL be ignored; conf changes while busy SHALL have no effect.
REQ-030 en_s=0 SHALL hold state, counters and accumulator, and force z_we=0 and done=0.
- Operation resumes exactly where it stopped when en_s returns high.
REQ-031 z_we SHALL never assert outside WRITE.
REQ-032 Unused address outputs SHALL hold their last value.

Reset
REQ-033 On rst_a=0, asynchronously: state=IDLE; busy, done, err, z_we = 0; x_addr, y_addr, z_addr, z_data, acc, k, j = 0.
REQ-034 Reset mid-operation SHALL abort with no done pulse and no further writes; the next start begins a fresh run.

Verification
REQ-035 Nx=1, Ny=1, x={3}, y={4}, full -> single write z[0]=12; done high in the 5th cycle after start is sampled.
REQ-036 Nx=3, Ny=2, x={1,2,3}, y={1,1}, full -> writes z[0..3]={1,3,5,3}; total 3+4+4+3 busy cycles plus SETUP/FIN as specified.
REQ-037 Same data, shape=0 -> writes z[0..2]={3,5,3} only; z_addr never reaches 3.
REQ-038 Nx=0 -> err=1, done pulse, zero z_we; the next valid start clears err.
REQ-039 Nx=Ny=1, x=0xFFFFFFFF, y=2 -> z[0]=0xFFFFFFFE (wrap check).
- Also covers start re-asserted while busy: ignored, exactly one done.
REQ-040 Drop en_s for 5 cycles mid-FETCH -> final results identical to the uninterrupted run.
- Also covers rst_a pulse mid-run: IDLE, busy=0, no done.
